// File: rtl/pixel_writer.sv
// pixel_writer: buffers the draw-stage pixel stream in a small FIFO and drives
// framebuffer port B. A clear request sweeps the whole frame with one colour
// before any buffered pixel is written, so geometry lands on a fresh frame.
// Optional feature: define PIXEL_WRITER_BOUNDS_CHECK_EN to discard popped
// pixels whose address is outside the frame and count them in drop_count_out.
module pixel_writer #(
  parameter int unsigned PIXEL_WIDTH  = 1280,
  parameter int unsigned PIXEL_HEIGHT = 720,
  parameter int unsigned FIFO_DEPTH   = 16,
  localparam int unsigned PIXEL_TOTAL = PIXEL_WIDTH * PIXEL_HEIGHT,
  localparam int unsigned AW          = $clog2(PIXEL_TOTAL)
) (
  input  logic          clk_in,
  input  logic          rst_in,
  input  logic          clear_in,
  input  logic [3:0]    clear_color_in,
  input  logic [AW:0]   pixel_addr_in,
  input  logic [3:0]    pixel_color_in,
  input  logic          pixel_valid_in,
  output logic          pixel_ready_out,
  output logic [AW-1:0] write_addr_out,
  output logic [3:0]    write_data_out,
  output logic          write_valid_out,
  output logic          clear_done_out,
  output logic          idle_out,
  output logic [15:0]   drop_count_out
);

  localparam int unsigned   CW         = $clog2(FIFO_DEPTH);
  localparam logic [CW:0]   FULL_COUNT = (CW + 1)'(FIFO_DEPTH);
  localparam logic [AW-1:0] LAST_ADDR  = AW'(PIXEL_TOTAL - 1);

  typedef enum logic [0:0] {StIdle, StClear} state_e;

  state_e        state;
  logic [AW+4:0] fifo_mem [FIFO_DEPTH];  // {addr, color}
  logic [CW-1:0] wr_ptr;
  logic [CW-1:0] rd_ptr;
  logic [CW:0]   count;
  logic [CW:0]   count_next;
  logic [AW-1:0] clr_ptr;
  logic [3:0]    clr_color;
  logic          push;
  logic          pop;
  logic          pop_write;
  logic          idle_next;
  logic [AW:0]   pop_addr;
  logic [3:0]    pop_color;

  // Ready is held low during reset so nothing is pushed into a flushing FIFO.
  assign pixel_ready_out = !rst_in && (count != FULL_COUNT);
  assign push = pixel_valid_in && pixel_ready_out;
  // A clear request in the same cycle takes priority over popping.
  assign pop  = (state == StIdle) && !clear_in && (count != '0);
  assign {pop_addr, pop_color} = fifo_mem[rd_ptr];

`ifdef PIXEL_WRITER_BOUNDS_CHECK_EN
  localparam logic [AW:0] TOTAL_W = (AW + 1)'(PIXEL_TOTAL);
  logic        pop_in_range;
  logic [15:0] drop_count;

  assign pop_in_range   = pop_addr < TOTAL_W;
  assign pop_write      = pop && pop_in_range;
  assign drop_count_out = drop_count;

  // Count discarded out-of-frame pixels, saturating.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      drop_count <= '0;
    end else if (pop && !pop_in_range && (drop_count != 16'hFFFF)) begin
      drop_count <= drop_count + 16'd1;
    end
  end
`else
  // Without the check the address MSB is simply truncated away.
  logic unused_pop_addr_msb;
  assign unused_pop_addr_msb = pop_addr[AW];
  assign pop_write           = pop;
  assign drop_count_out      = 16'h0000;
`endif

  // Occupancy after this cycle's push/pop.
  always_comb begin
    count_next = count;
    if (push && !pop) begin
      count_next = count + 1'b1;
    end else if (!push && pop) begin
      count_next = count - 1'b1;
    end
  end

  // Idle next cycle: staying in IDLE, FIFO drained and no write being issued.
  assign idle_next = (state == StIdle) && !clear_in && (count_next == '0) && !pop_write;

  // FIFO storage; the pointers alone define validity, so no reset is needed.
  always_ff @(posedge clk_in) begin
    if (push) begin
      fifo_mem[wr_ptr] <= {pixel_addr_in, pixel_color_in};
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count_next;
    end
  end

  // Sequencer FSM with registered port-B outputs.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state           <= StIdle;
      clr_ptr         <= '0;
      clr_color       <= '0;
      write_addr_out  <= '0;
      write_data_out  <= '0;
      write_valid_out <= 1'b0;
      clear_done_out  <= 1'b0;
      idle_out        <= 1'b1;
    end else begin
      write_valid_out <= 1'b0;
      clear_done_out  <= 1'b0;
      idle_out        <= idle_next;
      unique case (state)
        StIdle: begin
          if (clear_in) begin
            state     <= StClear;
            clr_color <= clear_color_in;
            clr_ptr   <= '0;
          end else if (pop_write) begin
            write_valid_out <= 1'b1;
            write_addr_out  <= pop_addr[AW-1:0];
            write_data_out  <= pop_color;
          end
        end
        StClear: begin
          // Further clear requests are ignored until the sweep completes.
          write_valid_out <= 1'b1;
          write_addr_out  <= clr_ptr;
          write_data_out  <= clr_color;
          clr_ptr         <= clr_ptr + 1'b1;
          if (clr_ptr == LAST_ADDR) begin
            clear_done_out <= 1'b1;
            state          <= StIdle;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_pixel_writer.sv
// Self-checking bench for pixel_writer (8x4 frame, 4-entry FIFO).
// Honours PIXEL_WRITER_BOUNDS_CHECK_EN when deciding out-of-frame expectations.
module tb_pixel_writer;
  localparam int W     = 8;
  localparam int H     = 4;
  localparam int D     = 4;
  localparam int TOTAL = W * H;
  localparam int AW    = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          clear = 1'b0;
  logic [3:0]    clear_color = '0;
  logic [AW:0]   paddr = '0;
  logic [3:0]    pcolor = '0;
  logic          pvalid = 1'b0;
  logic          ready;
  logic [AW-1:0] waddr;
  logic [3:0]    wdata;
  logic          wvalid;
  logic          done;
  logic          idle;
  logic [15:0]   drops;

  pixel_writer #(
    .PIXEL_WIDTH (W),
    .PIXEL_HEIGHT(H),
    .FIFO_DEPTH  (D)
  ) dut (
    .clk_in         (clk),
    .rst_in         (rst),
    .clear_in       (clear),
    .clear_color_in (clear_color),
    .pixel_addr_in  (paddr),
    .pixel_color_in (pcolor),
    .pixel_valid_in (pvalid),
    .pixel_ready_out(ready),
    .write_addr_out (waddr),
    .write_data_out (wdata),
    .write_valid_out(wvalid),
    .clear_done_out (done),
    .idle_out       (idle),
    .drop_count_out (drops)
  );

  always #5 clk = ~clk;

`ifdef PIXEL_WRITER_BOUNDS_CHECK_EN
  localparam bit BoundsCheck = 1'b1;
`else
  localparam bit BoundsCheck = 1'b0;
`endif

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int cyc;
    int done;
    int addr;
    int data;
  } wr_t;

  wr_t wq[$];   // writes observed on port B
  wr_t ewq[$];  // writes predicted by the model

  // Port-B monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (!rst && wvalid) wq.push_back('{cyc, int'(done), int'(waddr), int'(wdata)});
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic wait_idle(input string name);
    for (int k = 0; k < 80 && !idle; k++) @(negedge clk);
    check(name, 32'(idle), 32'd1);
  endtask

  typedef struct {
    logic [AW:0]   addr;
    logic [3:0]    color;
    logic          exp_valid;
    logic [AW-1:0] exp_addr;
    logic [3:0]    exp_data;
  } vec_t;

  vec_t vecs[6];
  int   px_a[5] = '{7, 3, 12, 20, 25};
  int   px_c[5] = '{9, 1, 5, 15, 6};

  initial begin
    int exp_drop;
    int occ;
    int idx;
    int clr_edge;
    int n;
    int dones;
    logic acc;

    vecs[0] = '{6'd5,  4'd3,  1'b1, 5'd5,  4'd3};
    vecs[1] = '{6'd0,  4'd15, 1'b1, 5'd0,  4'd15};
    vecs[2] = '{6'd31, 4'd7,  1'b1, 5'd31, 4'd7};
    vecs[3] = '{6'd17, 4'd10, 1'b1, 5'd17, 4'd10};
    vecs[4] = '{6'd32, 4'd1,  !BoundsCheck, 5'd0, 4'd1};
    vecs[5] = '{6'd40, 4'd4,  !BoundsCheck, 5'd8, 4'd4};

    // Reset values
    @(negedge clk);
    #1;
    check("rst_ready", 32'(ready), 32'd0);
    check("rst_wvalid", 32'(wvalid), 32'd0);
    check("rst_waddr", 32'(waddr), 32'd0);
    check("rst_wdata", 32'(wdata), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_drops", 32'(drops), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rel_idle", 32'(idle), 32'd1);
    check("rel_ready", 32'(ready), 32'd1);

    // Single pixels into an empty, idle writer: latency, idle, bounds handling
    exp_drop = 0;
    for (int i = 0; i < 6; i++) begin
      paddr  = vecs[i].addr;
      pcolor = vecs[i].color;
      pvalid = 1'b1;
      @(negedge clk);
      pvalid = 1'b0;
      check("tbl_idle_busy", 32'(idle), 32'd0);
      check("tbl_no_early_write", 32'(wvalid), 32'd0);
      @(negedge clk);
      check("tbl_wvalid", 32'(wvalid), 32'(vecs[i].exp_valid));
      if (vecs[i].exp_valid) begin
        check("tbl_waddr", 32'(waddr), 32'(vecs[i].exp_addr));
        check("tbl_wdata", 32'(wdata), 32'(vecs[i].exp_data));
      end else begin
        exp_drop++;
      end
      @(negedge clk);
      check("tbl_idle_after", 32'(idle), 32'd1);
      check("tbl_wvalid_after", 32'(wvalid), 32'd0);
      check("tbl_drops", 32'(drops), 32'(exp_drop));
    end

    // Six back-to-back pixels, valid held: one write per cycle, in order
    wq.delete();
    occ = 0;
    for (int i = 0; i < 6; i++) begin
      paddr  = 6'(2 * i + 2);
      pcolor = 4'(i + 1);
      pvalid = 1'b1;
      check("b2b_ready", 32'(ready), 32'(occ < D));
      if (occ > 0) occ--;
      occ++;
      @(negedge clk);
    end
    pvalid = 1'b0;
    wait_idle("b2b_idle");
    check("b2b_count", 32'(wq.size()), 32'd6);
    for (int i = 0; i < wq.size() && i < 6; i++) begin
      check("b2b_addr", 32'(wq[i].addr), 32'(2 * i + 2));
      check("b2b_data", 32'(wq[i].data), 32'(i + 1));
      check("b2b_cyc", 32'(wq[i].cyc - wq[0].cyc), 32'(i));
    end

    // Clear with a simultaneous push; more pixels fill the FIFO during the sweep
    wq.delete();
    occ = 0;
    idx = 0;
    clr_edge = 0;
    for (int c = 0; c < 100 && idx < 5; c++) begin
      if (c == 0) begin
        clear = 1'b1;
        clear_color = 4'd2;
        clr_edge = cyc + 1;
      end else begin
        clear = 1'b0;
      end
      pvalid = 1'b1;
      paddr  = 6'(px_a[idx]);
      pcolor = 4'(px_c[idx]);
      if (c <= 32) check("clr_ready", 32'(ready), 32'(occ < D));
      if (ready) begin
        idx++;
        occ++;
      end
      @(negedge clk);
    end
    clear  = 1'b0;
    pvalid = 1'b0;
    check("clr_all_pushed", 32'(idx), 32'd5);
    wait_idle("clr_idle");
    check("clr_count", 32'(wq.size()), 32'(TOTAL + 5));
    for (int i = 0; i < wq.size() && i < TOTAL; i++) begin
      check("clr_addr", 32'(wq[i].addr), 32'(i));
      check("clr_data", 32'(wq[i].data), 32'd2);
      check("clr_done", 32'(wq[i].done), 32'(i == TOTAL - 1));
      check("clr_cyc", 32'(wq[i].cyc), 32'(clr_edge + 1 + i));
    end
    for (int j = 0; j < 5 && TOTAL + j < wq.size(); j++) begin
      check("post_clr_addr", 32'(wq[TOTAL+j].addr), 32'(px_a[j]));
      check("post_clr_data", 32'(wq[TOTAL+j].data), 32'(px_c[j]));
      check("post_clr_cyc", 32'(wq[TOTAL+j].cyc), 32'(clr_edge + TOTAL + 1 + j));
    end

    // Second clear request mid-sweep is ignored
    wq.delete();
    clear = 1'b1;
    clear_color = 4'd6;
    @(negedge clk);
    clear = 1'b0;
    for (int k = 0; k < 50 && !(wvalid && waddr == 5'd10); k++) @(negedge clk);
    check("reclr_at10", 32'(wvalid && waddr == 5'd10), 32'd1);
    clear = 1'b1;
    clear_color = 4'd11;
    @(negedge clk);
    clear = 1'b0;
    wait_idle("reclr_idle");
    check("reclr_count", 32'(wq.size()), 32'(TOTAL));
    dones = 0;
    for (int i = 0; i < wq.size(); i++) begin
      dones += wq[i].done;
      check("reclr_addr", 32'(wq[i].addr), 32'(i));
      check("reclr_data", 32'(wq[i].data), 32'd6);
    end
    check("reclr_dones", 32'(dones), 32'd1);

    // Reset mid-sweep with pixels queued
    clear = 1'b1;
    clear_color = 4'd4;
    @(negedge clk);
    clear = 1'b0;
    for (int j = 0; j < 3; j++) begin
      pvalid = 1'b1;
      paddr  = 6'(px_a[j]);
      pcolor = 4'(px_c[j]);
      @(negedge clk);
    end
    pvalid = 1'b0;
    for (int k = 0; k < 50 && !(wvalid && waddr == 5'd12); k++) @(negedge clk);
    check("rstmid_at12", 32'(wvalid && waddr == 5'd12), 32'd1);
    rst = 1'b1;
    #1;
    check("rstmid_wvalid", 32'(wvalid), 32'd0);
    check("rstmid_ready", 32'(ready), 32'd0);
    check("rstmid_done", 32'(done), 32'd0);
    n = wq.size();
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    check("rstmid_no_writes", 32'(wq.size()), 32'(n));
    check("rstmid_idle", 32'(idle), 32'd1);
    check("rstmid_ready_after", 32'(ready), 32'd1);
    check("rstmid_drops", 32'(drops), 32'd0);

    // Randomized pixel stream against a transaction-level model
    wq.delete();
    ewq.delete();
    occ = 0;
    exp_drop = 0;
    for (int c = 0; c < 300; c++) begin
      pvalid = 1'($urandom_range(0, 1));
      paddr  = 6'($urandom_range(0, 45));
      pcolor = 4'($urandom_range(0, 15));
      check("rand_ready", 32'(ready), 32'(occ < D));
      acc = pvalid && (occ < D);
      if (occ > 0) occ--;
      if (acc) begin
        occ++;
        if (BoundsCheck && int'(paddr) >= TOTAL) exp_drop++;
        else ewq.push_back('{cyc + 2, 0, int'(paddr) % TOTAL, int'(pcolor)});
      end
      @(negedge clk);
    end
    pvalid = 1'b0;
    repeat (4) @(negedge clk);
    check("rand_count", 32'(wq.size()), 32'(ewq.size()));
    for (int i = 0; i < wq.size() && i < ewq.size(); i++) begin
      check("rand_addr", 32'(wq[i].addr), 32'(ewq[i].addr));
      check("rand_data", 32'(wq[i].data), 32'(ewq[i].data));
      check("rand_cyc", 32'(wq[i].cyc), 32'(ewq[i].cyc));
    end
    check("rand_drops", 32'(drops), 32'(exp_drop));
    check("rand_idle", 32'(idle), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/pixel_writer.md
# pixel_writer

Write-port sequencer between the rasterizing draw stages (polygon fill/edge generators) and port B of the 4-bit palette-index framebuffer. It buffers the `(addr, color, valid)` pixel stream in a small FIFO with backpressure. On request, it sweeps the whole framebuffer with a clear colour before letting buffered pixels through, so drawn geometry always lands on top of a freshly cleared frame.

## Interface
Parameters:
- `PIXEL_WIDTH`, default 1280: frame width in pixels.
- `PIXEL_HEIGHT`, default 720: frame height in pixels.
- `FIFO_DEPTH`, default 16: pixel FIFO entries; must be a power of two, ≥ 2.

Derived: `PIXEL_TOTAL = PIXEL_WIDTH*PIXEL_HEIGHT`, `AW = $clog2(PIXEL_TOTAL)`.

Ports:
- `clk_in`  in  1  sole clock.
- `rst_in`  in  1  reset; **one clock; reset is asynchronous and active-high**.
- `clear_in`  in  1  one-cycle request to clear the frame.
- `clear_color_in`  in  4  palette index used for the clear; sampled with `clear_in`.
- `pixel_addr_in`  in  AW+1  linear pixel address from the draw stage.
- `pixel_color_in`  in  4  palette index of that pixel.
- `pixel_valid_in`  in  1  pixel present this cycle.
- `pixel_ready_out`  out  1  FIFO can accept; transfer happens when valid & ready at a rising edge.
- `write_addr_out`  out  AW  framebuffer port-B address.
- `write_data_out`  out  4  framebuffer port-B data.
- `write_valid_out`  out  1  framebuffer port-B write enable.
- `clear_done_out`  out  1  one-cycle pulse after the last clear write.
- `idle_out`  out  1  IDLE state, FIFO empty, no write on port.
- `drop_count_out`  out  16  out-of-range pixels discarded (see Configuration).

## Operation
- States:
  - IDLE: on each cycle the FIFO is non-empty, pop one entry into the write registers.
  - CLEAR: write `clear_color` to address `clr_ptr`, then increment `clr_ptr`; no FIFO pops.
- IDLE → CLEAR: when `clear_in` is high.
  - Latch `clear_color_in`.
  - Set `clr_ptr=0`.
  - A pop that would occur in the same cycle is suppressed.
- CLEAR → IDLE: after the write of `clr_ptr==PIXEL_TOTAL-1`. `clear_done_out` pulses in the cycle that write is on the port.
- `clear_in` while in CLEAR: ignored; the sweep is not restarted.
- Pixel pushes:
  - Pushes continue in both states while `pixel_ready_out=1`.
  - `pixel_ready_out = !full` (from the registered occupancy count); it is low when full even if a pop occurs that cycle.
  - Pushes and pops in the same cycle are allowed; count is unchanged.
- FIFO ordering is strict; no reordering or merging of duplicate addresses.
- Widths: `pixel_addr_in` is AW+1 bits, and its MSB is significant only for the range check.

## Timing
- All outputs are registered except `pixel_ready_out`, which is a combinational decode of the registered count.
- Reset values:
  - `write_valid_out=0`, `write_addr_out=0`, `write_data_out=0`.
  - `clear_done_out=0`, `drop_count_out=0`.
  - `idle_out=1` (after reset release), state IDLE.
  - FIFO empty.
  - `pixel_ready_out=0` while `rst_in` is high, 1 after.
- Pixel latency: accepted at edge N with FIFO empty and state IDLE → `write_valid_out=1` with that pixel after edge N+1.
- Throughput: one write per cycle sustained in IDLE.
- Clear: `clear_in` sampled at edge N → first clear write (addr 0) after edge N+1. The sweep takes exactly PIXEL_TOTAL cycles, then the first buffered pixel appears in the next cycle.
- `idle_out` deasserts after the edge that accepts a pixel or a clear.
- Reset mid-operation:
  - Takes effect immediately.
  - Aborts the sweep and flushes the FIFO.
  - Forces `write_valid_out=0` with no further writes.

## Configuration
- Macro `PIXEL_WRITER_BOUNDS_CHECK_EN`.
- Defined:
  - A popped entry with `pixel_addr_in >= PIXEL_TOTAL` is discarded; it still consumes the pop cycle.
  - `write_valid_out=0` that cycle.
  - `drop_count_out` increments, saturating at 16'hFFFF.
- Undefined:
  - No check; the address is truncated to its low AW bits and written.
  - `drop_count_out` is constant 0.

## Test plan
All scenarios use W=8, H=4 (TOTAL 32, AW 5), FIFO_DEPTH 4.
- Reset, then push addr 5 color 3 → one cycle later: write addr 5, data 3, valid; `idle_out` returns to 1 after.
- Push 6 pixels back-to-back with `pixel_valid_in` held → ready drops only when full. All 6 are written in order, one per cycle, with no loss or duplication.
- `clear_in` with color 2, pushing addr 7 color 9 in the same cycle → 32 writes of data 2 to addr 0..31. `clear_done_out` pulses on addr 31, then addr 7 data 9 is written.
- `clear_in` pulsed again at sweep addr 10 → sweep continues to 31 unchanged; exactly 32 clear writes.
- Assert `rst_in` at sweep addr 12 with 3 pixels queued → valid low immediately. After release, no writes until new input; `idle_out=1`.
- Push addr 40 with the macro defined → no write and `drop_count_out=1`. With the macro undefined → write to addr 8 (40 mod 32).
